// File: rtl/bank1_slot_table_pkg.sv
// Shared definitions for the bank1 sequencer slot table and its AXI-Lite front ends.
// Provides widths, field-select codes, status codes and the row snapshot layout.
package bank1_slot_table_pkg;

   localparam int unsigned INDEX_WIDTH     = 3;
   localparam int unsigned NUM_SLOTS       = 1 << INDEX_WIDTH;
   localparam int unsigned SRC_ADDR_WIDTH  = 32;
   localparam int unsigned SRC_SIZE_WIDTH  = 26;
   localparam int unsigned DST_ADDR_WIDTH  = 32;
   localparam int unsigned DST_SIZE_WIDTH  = 26;
   localparam int unsigned STATUS_WIDTH    = 2;
   localparam int unsigned PROFILE_WIDTH   = 32;
   localparam int unsigned LD_MSK_WIDTH    = 8;
   localparam int unsigned ST_MSK_WIDTH    = 8;
   localparam int unsigned DATA_WIDTH      = 32;
   localparam int unsigned FIELD_SEL_WIDTH = 4;

   typedef enum logic [FIELD_SEL_WIDTH-1:0] {
      FLD_SRC_ADDR    = 4'd0,
      FLD_SRC_SIZE    = 4'd1,
      FLD_DES_ADDR    = 4'd2,
      FLD_DES_SIZE    = 4'd3,
      FLD_STATUS      = 4'd4,
      FLD_PROFILE     = 4'd5,
      FLD_LD_MASK     = 4'd6,
      FLD_ST_MASK     = 4'd7,
      FLD_ST_INTR_ABS = 4'd8
   } field_e;

   typedef enum logic [STATUS_WIDTH-1:0] {
      ST_IDLE    = 2'b00,
      ST_RUNNING = 2'b01,
      ST_DONE    = 2'b10,
      ST_ERR     = 2'b11
   } status_e;

   // One full slot row as presented to the sequencer core.
   typedef struct packed {
      logic [SRC_ADDR_WIDTH-1:0] src_addr;
      logic [SRC_SIZE_WIDTH-1:0] src_size;
      logic [DST_ADDR_WIDTH-1:0] des_addr;
      logic [DST_SIZE_WIDTH-1:0] des_size;
      logic [STATUS_WIDTH-1:0]   status;
      logic [PROFILE_WIDTH-1:0]  profile;
      logic [LD_MSK_WIDTH-1:0]   ld_mask;
      logic [ST_MSK_WIDTH-1:0]   st_mask;
      logic [ST_MSK_WIDTH-1:0]   st_intr_mask_abs;
   } slot_row_t;

endpackage

// File: rtl/bank1_slot_table_if.sv
// Host write/read, sequencer read and sequencer writeback signals of the bank1 slot table.
// master = front ends / sequencer side, slave = the table.
interface bank1_slot_table_if;
   import bank1_slot_table_pkg::*;

   logic [INDEX_WIDTH-1:0]     host_index;
   logic [DATA_WIDTH-1:0]      host_src_addr;
   logic [DATA_WIDTH-1:0]      host_src_size;
   logic [DATA_WIDTH-1:0]      host_des_addr;
   logic [DATA_WIDTH-1:0]      host_des_size;
   logic [DATA_WIDTH-1:0]      host_status;
   logic [DATA_WIDTH-1:0]      host_profile;
   logic [DATA_WIDTH-1:0]      host_ld_mask;
   logic [DATA_WIDTH-1:0]      host_st_mask;
   logic [DATA_WIDTH-1:0]      host_st_intr_mask_abs;
   logic                       host_set_src_addr;
   logic                       host_set_src_size;
   logic                       host_set_des_addr;
   logic                       host_set_des_size;
   logic                       host_set_status;
   logic                       host_set_profile;
   logic                       host_set_ld_mask;
   logic                       host_set_st_mask;
   logic                       host_set_fin_st_intr_mask_abs;

   logic [INDEX_WIDTH-1:0]     host_rd_index;
   logic [FIELD_SEL_WIDTH-1:0] host_rd_field;
   logic [DATA_WIDTH-1:0]      host_rd_data;

   logic                       seq_rd_en;
   logic [INDEX_WIDTH-1:0]     seq_rd_index;
   logic                       seq_rd_valid;
   logic [SRC_ADDR_WIDTH-1:0]  seq_src_addr;
   logic [SRC_SIZE_WIDTH-1:0]  seq_src_size;
   logic [DST_ADDR_WIDTH-1:0]  seq_des_addr;
   logic [DST_SIZE_WIDTH-1:0]  seq_des_size;
   logic [STATUS_WIDTH-1:0]    seq_status;
   logic [PROFILE_WIDTH-1:0]   seq_profile;
   logic [LD_MSK_WIDTH-1:0]    seq_ld_mask;
   logic [ST_MSK_WIDTH-1:0]    seq_st_mask;
   logic [ST_MSK_WIDTH-1:0]    seq_st_intr_mask_abs;

   logic                       seq_upd_en;
   logic [INDEX_WIDTH-1:0]     seq_upd_index;
   logic [STATUS_WIDTH-1:0]    seq_upd_status;
   logic                       seq_prof_inc;
   logic [NUM_SLOTS-1:0]       slot_busy;

   modport master (
      output host_index, host_src_addr, host_src_size, host_des_addr, host_des_size,
             host_status, host_profile, host_ld_mask, host_st_mask, host_st_intr_mask_abs,
             host_set_src_addr, host_set_src_size, host_set_des_addr, host_set_des_size,
             host_set_status, host_set_profile, host_set_ld_mask, host_set_st_mask,
             host_set_fin_st_intr_mask_abs, host_rd_index, host_rd_field,
             seq_rd_en, seq_rd_index, seq_upd_en, seq_upd_index, seq_upd_status, seq_prof_inc,
      input  host_rd_data, seq_rd_valid, seq_src_addr, seq_src_size, seq_des_addr,
             seq_des_size, seq_status, seq_profile, seq_ld_mask, seq_st_mask,
             seq_st_intr_mask_abs, slot_busy
   );

   modport slave (
      input  host_index, host_src_addr, host_src_size, host_des_addr, host_des_size,
             host_status, host_profile, host_ld_mask, host_st_mask, host_st_intr_mask_abs,
             host_set_src_addr, host_set_src_size, host_set_des_addr, host_set_des_size,
             host_set_status, host_set_profile, host_set_ld_mask, host_set_st_mask,
             host_set_fin_st_intr_mask_abs, host_rd_index, host_rd_field,
             seq_rd_en, seq_rd_index, seq_upd_en, seq_upd_index, seq_upd_status, seq_prof_inc,
      output host_rd_data, seq_rd_valid, seq_src_addr, seq_src_size, seq_des_addr,
             seq_des_size, seq_status, seq_profile, seq_ld_mask, seq_st_mask,
             seq_st_intr_mask_abs, slot_busy
   );

endinterface

// File: rtl/bank1_slot_table.sv
// Bank1 sequencer slot table: per-slot descriptor flops with host write/read ports,
// a registered sequencer row read, status writeback and a saturating profile counter.
module bank1_slot_table
   import bank1_slot_table_pkg::*;
(
   input logic               clk,
   input logic               reset,
   bank1_slot_table_if.slave bus
);

   logic [SRC_ADDR_WIDTH-1:0] src_addr_q  [NUM_SLOTS];
   logic [SRC_SIZE_WIDTH-1:0] src_size_q  [NUM_SLOTS];
   logic [DST_ADDR_WIDTH-1:0] des_addr_q  [NUM_SLOTS];
   logic [DST_SIZE_WIDTH-1:0] des_size_q  [NUM_SLOTS];
   logic [STATUS_WIDTH-1:0]   status_q    [NUM_SLOTS];
   logic [PROFILE_WIDTH-1:0]  profile_q   [NUM_SLOTS];
   logic [LD_MSK_WIDTH-1:0]   ld_mask_q   [NUM_SLOTS];
   logic [ST_MSK_WIDTH-1:0]   st_mask_q   [NUM_SLOTS];
   logic [ST_MSK_WIDTH-1:0]   st_intr_q   [NUM_SLOTS];

   slot_row_t            rd_row_c;
   slot_row_t            snap_q;
   logic                 rd_valid_q;
   logic [DATA_WIDTH-1:0] host_rd_data_c;
   logic [NUM_SLOTS-1:0]  busy_c;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) src_addr_q[i] <= '0;
      end else if (bus.host_set_src_addr) begin
         src_addr_q[bus.host_index] <= bus.host_src_addr[SRC_ADDR_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) src_size_q[i] <= '0;
      end else if (bus.host_set_src_size) begin
         src_size_q[bus.host_index] <= bus.host_src_size[SRC_SIZE_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) des_addr_q[i] <= '0;
      end else if (bus.host_set_des_addr) begin
         des_addr_q[bus.host_index] <= bus.host_des_addr[DST_ADDR_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) des_size_q[i] <= '0;
      end else if (bus.host_set_des_size) begin
         des_size_q[bus.host_index] <= bus.host_des_size[DST_SIZE_WIDTH-1:0];
      end
   end

   // Host write is assigned last so it wins a same-slot collision with writeback.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) status_q[i] <= '0;
      end else begin
         if (bus.seq_upd_en) status_q[bus.seq_upd_index] <= bus.seq_upd_status;
         if (bus.host_set_status) status_q[bus.host_index] <= bus.host_status[STATUS_WIDTH-1:0];
      end
   end

   // Saturating increment; a same-slot host write overrides and drops the increment.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) profile_q[i] <= '0;
      end else begin
         if (bus.seq_prof_inc && (profile_q[bus.seq_upd_index] != '1)) begin
            profile_q[bus.seq_upd_index] <= profile_q[bus.seq_upd_index] + PROFILE_WIDTH'(1);
         end
         if (bus.host_set_profile) profile_q[bus.host_index] <= bus.host_profile[PROFILE_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) ld_mask_q[i] <= '0;
      end else if (bus.host_set_ld_mask) begin
         ld_mask_q[bus.host_index] <= bus.host_ld_mask[LD_MSK_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) st_mask_q[i] <= '0;
      end else if (bus.host_set_st_mask) begin
         st_mask_q[bus.host_index] <= bus.host_st_mask[ST_MSK_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) st_intr_q[i] <= '0;
      end else if (bus.host_set_fin_st_intr_mask_abs) begin
         st_intr_q[bus.host_index] <= bus.host_st_intr_mask_abs[ST_MSK_WIDTH-1:0];
      end
   end

   always_comb begin
      rd_row_c = '{
         src_addr:         src_addr_q[bus.seq_rd_index],
         src_size:         src_size_q[bus.seq_rd_index],
         des_addr:         des_addr_q[bus.seq_rd_index],
         des_size:         des_size_q[bus.seq_rd_index],
         status:           status_q[bus.seq_rd_index],
         profile:          profile_q[bus.seq_rd_index],
         ld_mask:          ld_mask_q[bus.seq_rd_index],
         st_mask:          st_mask_q[bus.seq_rd_index],
         st_intr_mask_abs: st_intr_q[bus.seq_rd_index]
      };
   end

   // Snapshot samples pre-edge contents, so same-edge host writes show up on the next read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_q     <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.seq_rd_en;
         if (bus.seq_rd_en) snap_q <= rd_row_c;
      end
   end

   always_comb begin
      host_rd_data_c = '0;
      case (bus.host_rd_field)
         FLD_SRC_ADDR:    host_rd_data_c = DATA_WIDTH'(src_addr_q[bus.host_rd_index]);
         FLD_SRC_SIZE:    host_rd_data_c = DATA_WIDTH'(src_size_q[bus.host_rd_index]);
         FLD_DES_ADDR:    host_rd_data_c = DATA_WIDTH'(des_addr_q[bus.host_rd_index]);
         FLD_DES_SIZE:    host_rd_data_c = DATA_WIDTH'(des_size_q[bus.host_rd_index]);
         FLD_STATUS:      host_rd_data_c = DATA_WIDTH'(status_q[bus.host_rd_index]);
         FLD_PROFILE:     host_rd_data_c = DATA_WIDTH'(profile_q[bus.host_rd_index]);
         FLD_LD_MASK:     host_rd_data_c = DATA_WIDTH'(ld_mask_q[bus.host_rd_index]);
         FLD_ST_MASK:     host_rd_data_c = DATA_WIDTH'(st_mask_q[bus.host_rd_index]);
         FLD_ST_INTR_ABS: host_rd_data_c = DATA_WIDTH'(st_intr_q[bus.host_rd_index]);
         default:         host_rd_data_c = '0;
      endcase
   end

   // Busy flags are a direct decode of the status flops.
   always_comb begin
      busy_c = '0;
      for (int unsigned i = 0; i < NUM_SLOTS; i++) busy_c[i] = (status_q[i] == ST_RUNNING);
   end

   assign bus.host_rd_data         = host_rd_data_c;
   assign bus.slot_busy            = busy_c;
   assign bus.seq_rd_valid         = rd_valid_q;
   assign bus.seq_src_addr         = snap_q.src_addr;
   assign bus.seq_src_size         = snap_q.src_size;
   assign bus.seq_des_addr         = snap_q.des_addr;
   assign bus.seq_des_size         = snap_q.des_size;
   assign bus.seq_status           = snap_q.status;
   assign bus.seq_profile          = snap_q.profile;
   assign bus.seq_ld_mask          = snap_q.ld_mask;
   assign bus.seq_st_mask          = snap_q.st_mask;
   assign bus.seq_st_intr_mask_abs = snap_q.st_intr_mask_abs;

endmodule
